// File: rtl/pdp_types_pkg.sv
// Shared PDP-8 types: decoded opcode structs, opcode field values and the IFD state enum.
// Also supplies the default for the `ADDR_WIDTH macro when the build does not set it.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif

package pdp_types_pkg;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_TAD = 3'd1;
  localparam logic [2:0] OP_ISZ = 3'd2;
  localparam logic [2:0] OP_DCA = 3'd3;
  localparam logic [2:0] OP_JMS = 3'd4;
  localparam logic [2:0] OP_JMP = 3'd5;
  localparam logic [2:0] OP_IOT = 3'd6;
  localparam logic [2:0] OP_OPR = 3'd7;

  typedef struct packed {
    logic and_op;
    logic tad;
    logic isz;
    logic dca;
    logic jms;
    logic jmp;
  } pdp_mem_opcode_s;

  typedef struct packed {
    logic nop;
    logic iac;
    logic ral;
    logic rtl;
    logic rar;
    logic rtr;
    logic cml;
    logic cma;
    logic cia;
    logic cll;
    logic cla1;
    logic cla_cll;
    logic hlt;
    logic osr;
    logic skp;
    logic snl;
    logic szl;
    logic sza;
    logic sna;
    logic sma;
    logic spa;
    logic cla2;
  } pdp_op7_opcode_s;

  typedef enum logic [1:0] {
    StFetch,
    StMemWait,
    StHold,
    StRelease
  } ifd_state_e;

endpackage

// File: rtl/ifd_fetch_decode_decoder.sv
// Combinational PDP-8 instruction decoder: word plus fetch PC to opcode structs, operand
// address, indirect bit and an unsupported-word flag (IOT and group-3 OPR).
module ifd_decoder
  import pdp_types_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH
) (
  input  logic [11:0]           word_i,
  input  logic [ADDR_WIDTH-1:0] fetch_pc_i,
  output pdp_mem_opcode_s       mem_op_o,
  output pdp_op7_opcode_s       op7_o,
  output logic [ADDR_WIDTH-1:0] base_addr_o,
  output logic                  indirect_o,
  output logic                  unsupported_o
);

  logic [2:0]            opcode;
  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] page_base;

  assign opcode    = word_i[11:9];
  assign offset    = ADDR_WIDTH'(word_i[6:0]);
  assign page_base = fetch_pc_i & ~ADDR_WIDTH'(7'h7f);

  always_comb begin
    mem_op_o      = '0;
    op7_o         = '0;
    base_addr_o   = '0;
    indirect_o    = 1'b0;
    unsupported_o = 1'b0;
    case (opcode)
      OP_AND:  mem_op_o.and_op = 1'b1;
      OP_TAD:  mem_op_o.tad    = 1'b1;
      OP_ISZ:  mem_op_o.isz    = 1'b1;
      OP_DCA:  mem_op_o.dca    = 1'b1;
      OP_JMS:  mem_op_o.jms    = 1'b1;
      OP_JMP:  mem_op_o.jmp    = 1'b1;
      OP_IOT:  unsupported_o   = 1'b1;
      default: begin
        if (!word_i[8]) begin
          // Group 1: CIA and CLA_CLL replace their component flags.
          op7_o.nop     = (word_i[7:0] == 8'd0);
          op7_o.iac     = word_i[0] & ~word_i[5];
          op7_o.cma     = word_i[5] & ~word_i[0];
          op7_o.cia     = word_i[5] & word_i[0];
          op7_o.ral     = word_i[2] & ~word_i[1];
          op7_o.rtl     = word_i[2] & word_i[1];
          op7_o.rar     = word_i[3] & ~word_i[1];
          op7_o.rtr     = word_i[3] & word_i[1];
          op7_o.cml     = word_i[4];
          op7_o.cll     = word_i[6] & ~word_i[7];
          op7_o.cla1    = word_i[7] & ~word_i[6];
          op7_o.cla_cll = word_i[7] & word_i[6];
        end else if (word_i[0]) begin
          unsupported_o = 1'b1;
        end else begin
          op7_o.cla2 = word_i[7];
          op7_o.osr  = word_i[2];
          op7_o.hlt  = word_i[1];
          if (!word_i[3]) begin
            op7_o.sma = word_i[6];
            op7_o.sza = word_i[5];
            op7_o.snl = word_i[4];
          end else begin
            op7_o.spa = word_i[6];
            op7_o.sna = word_i[5];
            op7_o.szl = word_i[4];
            op7_o.skp = (word_i[6:4] == 3'd0);
          end
        end
      end
    endcase
    if (opcode < OP_IOT) begin
      indirect_o  = word_i[8];
      base_addr_o = word_i[7] ? (page_base | offset) : offset;
    end
  end

endmodule

// File: rtl/ifd_fetch_decode.sv
// PDP-8 instruction fetch/decode unit with exec stall/PC handshake.
// Optional IFD_PERF_CNT_EN adds saturating instr_count/skip_count outputs.
module ifd_fetch_decode
  import pdp_types_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = `ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'(12'o0200)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [ADDR_WIDTH-1:0] PC_value,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  indirect,
  output pdp_mem_opcode_s       pdp_mem_opcode,
  output pdp_op7_opcode_s       pdp_op7_opcode
`ifdef IFD_PERF_CNT_EN
  ,
  output logic [31:0]           instr_count,
  output logic [15:0]           skip_count
`endif
);

  ifd_state_e            state_q;
  logic [ADDR_WIDTH-1:0] fetch_pc_q;
  logic [ADDR_WIDTH-1:0] base_addr_q;
  logic                  indirect_q;
  pdp_mem_opcode_s       mem_op_q;
  pdp_op7_opcode_s       op7_q;

  pdp_mem_opcode_s       dec_mem_op;
  pdp_op7_opcode_s       dec_op7;
  logic [ADDR_WIDTH-1:0] dec_base_addr;
  logic                  dec_indirect;
  logic                  dec_unsupported;

  ifd_decoder #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_decoder (
    .word_i       (mem_rd_data),
    .fetch_pc_i   (fetch_pc_q),
    .mem_op_o     (dec_mem_op),
    .op7_o        (dec_op7),
    .base_addr_o  (dec_base_addr),
    .indirect_o   (dec_indirect),
    .unsupported_o(dec_unsupported)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StFetch;
      fetch_pc_q  <= START_ADDR;
      base_addr_q <= '0;
      indirect_q  <= 1'b0;
      mem_op_q    <= '0;
      op7_q       <= '0;
    end else begin
      unique case (state_q)
        StFetch: state_q <= StMemWait;
        StMemWait: begin
          if (dec_unsupported) begin
            fetch_pc_q <= fetch_pc_q + 1'b1;
            state_q    <= StFetch;
          end else begin
            base_addr_q <= dec_base_addr;
            indirect_q  <= dec_indirect;
            mem_op_q    <= dec_mem_op;
            op7_q       <= dec_op7;
            state_q     <= StHold;
          end
        end
        StHold: begin
          if (stall) begin
            indirect_q <= 1'b0;
            mem_op_q   <= '0;
            op7_q      <= '0;
            state_q    <= StRelease;
          end
        end
        StRelease: begin
          if (!stall) begin
            fetch_pc_q <= PC_value;
            state_q    <= StFetch;
          end
        end
        default: state_q <= StFetch;
      endcase
    end
  end

  // Gated by reset so the strobe stays low while reset is held.
  assign mem_rd_req     = (state_q == StFetch) & ~reset;
  assign mem_addr       = mem_rd_req ? fetch_pc_q : '0;
  assign base_addr      = base_addr_q;
  assign indirect       = indirect_q;
  assign pdp_mem_opcode = mem_op_q;
  assign pdp_op7_opcode = op7_q;

`ifdef IFD_PERF_CNT_EN
  logic [31:0] instr_count_q;
  logic [15:0] skip_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count_q <= '0;
      skip_count_q  <= '0;
    end else if (state_q == StMemWait) begin
      if (dec_unsupported) begin
        if (~&skip_count_q) skip_count_q <= skip_count_q + 1'b1;
      end else begin
        if (~&instr_count_q) instr_count_q <= instr_count_q + 1'b1;
      end
    end
  end

  assign instr_count = instr_count_q;
  assign skip_count  = skip_count_q;
`endif

endmodule

// File: tb/tb_ifd_fetch_decode.sv
// Self-checking bench for ifd_fetch_decode: directed vector table, hand sequences for
// unsupported words, wrap and reset-in-release, then random words against a decode model.
module tb_ifd_fetch_decode;
  import pdp_types_pkg::*;

  typedef struct packed {
    pdp_mem_opcode_s mem;
    pdp_op7_opcode_s op7;
    logic [11:0]     base;
    logic            ind;
    logic            unsup;
  } exp_t;

  typedef struct {
    logic [11:0] pc;
    logic [11:0] word;
    int          hold_n;
    exp_t        e;
  } vec_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            stall;
  logic [11:0]     PC_value;
  logic            mem_rd_req;
  logic [11:0]     mem_addr;
  logic [11:0]     mem_rd_data = '0;
  logic [11:0]     base_addr;
  logic            indirect;
  pdp_mem_opcode_s mem_op;
  pdp_op7_opcode_s op7;
`ifdef IFD_PERF_CNT_EN
  logic [31:0]     instr_count;
  logic [15:0]     skip_count;
`endif

  logic [11:0] mem [4096];
  logic [11:0] cur_pc;
  int          errors = 0;
  int          checks = 0;
  int          n_instr = 0;
  int          n_skip = 0;

  ifd_fetch_decode dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .PC_value      (PC_value),
    .mem_rd_req    (mem_rd_req),
    .mem_addr      (mem_addr),
    .mem_rd_data   (mem_rd_data),
    .base_addr     (base_addr),
    .indirect      (indirect),
    .pdp_mem_opcode(mem_op),
`ifdef IFD_PERF_CNT_EN
    .pdp_op7_opcode(op7),
    .instr_count   (instr_count),
    .skip_count    (skip_count)
`else
    .pdp_op7_opcode(op7)
`endif
  );

  always #5 clk = ~clk;

  // One-cycle read latency instruction memory.
  always @(posedge clk) if (mem_rd_req) mem_rd_data <= mem[mem_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit has(input int w, input int b);
    return ((w >> b) & 1) == 1;
  endfunction

  // Reference decode computed directly from the instruction-set rules.
  function automatic exp_t model(input logic [11:0] word, input logic [11:0] pc);
    exp_t e;
    int   w, op, off;
    e   = '0;
    w   = int'(word);
    op  = w / 512;
    off = w % 128;
    if (op == 6 || (op == 7 && has(w, 8) && has(w, 0))) begin
      e.unsup = 1'b1;
    end else if (op < 6) begin
      e.mem  = pdp_mem_opcode_s'(6'b100000 >> op);  // AND is the first (MSB) field
      e.ind  = has(w, 8);
      e.base = 12'(has(w, 7) ? (int'(pc) / 128) * 128 + off : off);
    end else if (!has(w, 8)) begin
      e.op7.nop     = (w == 'o7000);
      e.op7.cia     = has(w, 5) && has(w, 0);
      e.op7.iac     = has(w, 0) && !e.op7.cia;
      e.op7.cma     = has(w, 5) && !e.op7.cia;
      e.op7.ral     = has(w, 2) && !has(w, 1);
      e.op7.rtl     = has(w, 2) && has(w, 1);
      e.op7.rar     = has(w, 3) && !has(w, 1);
      e.op7.rtr     = has(w, 3) && has(w, 1);
      e.op7.cml     = has(w, 4);
      e.op7.cla_cll = has(w, 7) && has(w, 6);
      e.op7.cla1    = has(w, 7) && !e.op7.cla_cll;
      e.op7.cll     = has(w, 6) && !e.op7.cla_cll;
    end else begin
      e.op7.cla2 = has(w, 7);
      e.op7.osr  = has(w, 2);
      e.op7.hlt  = has(w, 1);
      if (has(w, 3)) begin
        e.op7.spa = has(w, 6);
        e.op7.sna = has(w, 5);
        e.op7.szl = has(w, 4);
        e.op7.skp = ((w / 16) % 8) == 0;
      end else begin
        e.op7.sma = has(w, 6);
        e.op7.sza = has(w, 5);
        e.op7.snl = has(w, 4);
      end
    end
    return e;
  endfunction

  task automatic wait_fetch(input logic [11:0] a);
    int n = 0;
    #1;
    while (!mem_rd_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_req", 64'(mem_rd_req), 64'd1);
    chk("fetch_addr", 64'(mem_addr), 64'(a));
  endtask

  task automatic chk_outputs(input string tag, input exp_t e);
    chk({tag, "_mem_op"}, 64'(mem_op), 64'(e.mem));
    chk({tag, "_op7"}, 64'(op7), 64'(e.op7));
    chk({tag, "_base"}, 64'(base_addr), 64'(e.base));
    chk({tag, "_ind"}, 64'(indirect), 64'(e.ind));
  endtask

  // Called mid-FETCH at cur_pc; returns mid-FETCH at the next fetch address.
  task automatic exec_instr(input logic [11:0] word, input exp_t e, input logic [11:0] next_pc,
                            input int hold_n, input int stall_n);
    logic [11:0] nx;
    mem[cur_pc] = word;
    @(negedge clk);
    @(negedge clk);
    if (e.unsup) begin
      nx = cur_pc + 12'd1;
      chk("unsup_mem_op", 64'(mem_op), 64'd0);
      chk("unsup_op7", 64'(op7), 64'd0);
      chk("unsup_ind", 64'(indirect), 64'd0);
      chk("unsup_req", 64'(mem_rd_req), 64'd1);
      chk("unsup_next_addr", 64'(mem_addr), 64'(nx));
      cur_pc = nx;
      n_skip++;
    end else begin
      n_instr++;
      chk_outputs("hold", e);
      chk("hold_req", 64'(mem_rd_req), 64'd0);
      if (hold_n > 0) begin
        repeat (hold_n) @(negedge clk);
        chk_outputs("hold_stable", e);
      end
      stall    = 1'b1;
      PC_value = next_pc;
      repeat (stall_n) begin
        @(negedge clk);
        chk("rel_mem_op", 64'(mem_op), 64'd0);
        chk("rel_op7", 64'(op7), 64'd0);
        chk("rel_ind", 64'(indirect), 64'd0);
        chk("rel_base", 64'(base_addr), 64'(e.base));
        chk("rel_req", 64'(mem_rd_req), 64'd0);
      end
      stall = 1'b0;
      wait_fetch(next_pc);
      cur_pc = next_pc;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[10];
    exp_t        e;
    logic [11:0] w, npc;

    for (int i = 0; i < 4096; i++) mem[i] = '0;
    for (int i = 0; i < 10; i++) begin
      tbl[i].e      = '0;
      tbl[i].hold_n = 0;
    end
    tbl[0].pc = 12'o0200; tbl[0].word = 12'o1205; tbl[0].hold_n = 15;
    tbl[0].e.mem.tad = 1'b1; tbl[0].e.base = 12'o0205;
    tbl[1].pc = 12'o0300; tbl[1].word = 12'o7001; tbl[1].e.op7.iac     = 1'b1;
    tbl[2].pc = 12'o0301; tbl[2].word = 12'o7041; tbl[2].e.op7.cia     = 1'b1;
    tbl[3].pc = 12'o0302; tbl[3].word = 12'o7300; tbl[3].e.op7.cla_cll = 1'b1;
    tbl[4].pc = 12'o0303; tbl[4].word = 12'o7510; tbl[4].e.op7.spa     = 1'b1;
    tbl[5].pc = 12'o0304; tbl[5].word = 12'o7410; tbl[5].e.op7.skp     = 1'b1;
    tbl[6].pc = 12'o0305; tbl[6].word = 12'o7402; tbl[6].e.op7.hlt     = 1'b1;
    tbl[7].pc = 12'o0400; tbl[7].word = 12'o5777;
    tbl[7].e.mem.jmp = 1'b1; tbl[7].e.ind = 1'b1; tbl[7].e.base = 12'o0577;
    tbl[8].pc = 12'o0401; tbl[8].word = 12'o7000; tbl[8].e.op7.nop     = 1'b1;
    tbl[9].pc = 12'o0402; tbl[9].word = 12'o3052;
    tbl[9].e.mem.dca = 1'b1; tbl[9].e.base = 12'o0052;

    reset    = 1'b1;
    stall    = 1'b0;
    PC_value = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", 64'(mem_rd_req), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk_outputs("rst", '0);
`ifdef IFD_PERF_CNT_EN
    chk("rst_instr_count", 64'(instr_count), 64'd0);
    chk("rst_skip_count", 64'(skip_count), 64'd0);
`endif
    reset = 1'b0;
    wait_fetch(12'o0200);
    cur_pc = 12'o0200;

    for (int i = 0; i < 10; i++) begin
      npc = (i < 9) ? tbl[i + 1].pc : 12'o0201;
      exec_instr(tbl[i].word, tbl[i].e, npc, tbl[i].hold_n, 3);
    end

    // IOT skip, then an unsupported word at 7777 wrapping the fetch PC to 0000.
    e = '0; e.unsup = 1'b1;
    exec_instr(12'o6046, e, 12'o0000, 0, 1);
    e = '0; e.mem.tad = 1'b1; e.base = 12'o0005;
    exec_instr(12'o1005, e, 12'o7777, 1, 2);
    e = '0; e.unsup = 1'b1;
    exec_instr(12'o6000, e, 12'o0000, 0, 1);
    e = '0; e.mem.isz = 1'b1; e.base = 12'o0010;
    exec_instr(12'o2010, e, 12'o1234, 0, 1);
    e = '0; e.unsup = 1'b1;
    exec_instr(12'o7401, e, 12'o0000, 0, 1);

    for (int i = 0; i < 40; i++) begin
      w   = 12'($urandom_range(0, 4095));
      npc = 12'($urandom_range(0, 4095));
      exec_instr(w, model(w, cur_pc), npc, $urandom_range(0, 3), $urandom_range(1, 3));
    end

    // Reset while in RELEASE with a pending PC_value.
    mem[cur_pc] = 12'o1205;
    @(negedge clk);
    @(negedge clk);
    stall    = 1'b1;
    PC_value = 12'o0300;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rrel_req", 64'(mem_rd_req), 64'd0);
    chk_outputs("rrel", '0);
    stall = 1'b0;
    reset = 1'b0;
    n_instr = 0;
    n_skip  = 0;
    wait_fetch(12'o0200);
    cur_pc = 12'o0200;

    exec_instr(12'o1205, model(12'o1205, 12'o0200), 12'o0210, 0, 1);
    exec_instr(12'o7001, model(12'o7001, 12'o0210), 12'o0220, 0, 1);
    exec_instr(12'o7402, model(12'o7402, 12'o0220), 12'o0230, 0, 1);
    exec_instr(12'o6046, model(12'o6046, 12'o0230), 12'o0000, 0, 1);
`ifdef IFD_PERF_CNT_EN
    chk("instr_count", 64'(instr_count), 64'd3);
    chk("skip_count", 64'(skip_count), 64'd1);
`else
    chk("after_iot_addr", 64'(mem_addr), 64'o0231);
`endif
    chk("model_counts", 64'(n_instr * 16 + n_skip), 64'(3 * 16 + 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
